clk_div_monitor: RTL and testbench

CLK_DIV_MONITOR -- requirements
Module: clk_div_monitor

---
 rtl/clk_div_monitor.sv | 103 ++++++++++
 tb/tb_clk_div_monitor.sv | 129 ++++++++++++
 2 files changed

// File: rtl/clk_div_monitor.sv
// clk_div_monitor: measures a divided clock's period and tracks lock/loss against EXP_PERIOD +/- TOL
// Define CLK_MON_STICKY_ERR_EN to enable the sticky loss flag err_sticky.
module clk_div_monitor #(
  parameter int CNT_W      = 8,
  parameter int EXP_PERIOD = 8,
  parameter int TOL        = 1,
  parameter int LOCK_CNT   = 4
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             clk_div_in,
  input  logic             err_clr,
  output logic             edge_rise,
  output logic             edge_fall,
  output logic [CNT_W-1:0] period_out,
  output logic             period_valid,
  output logic             locked,
  output logic             lost_pulse,
  output logic [1:0]       state,
  output logic             err_sticky
);
  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED, LOST} state_t;
  localparam int GW = $clog2(LOCK_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] TMO = CNT_W'(EXP_PERIOD + TOL);
  localparam logic [CNT_W:0] EXP_W = (CNT_W+1)'(EXP_PERIOD);
  localparam logic [CNT_W:0] TOL_W = (CNT_W+1)'(TOL);
  logic s1, s2, s3;
  logic [CNT_W-1:0] cnt, period;
  logic [CNT_W:0] period_w, diff;
  logic good, timeout, lost_nxt;
  logic [GW-1:0] good_cnt, good_nxt;
  state_t cur, nxt;
  assign period   = (cnt == CNT_MAX) ? CNT_MAX : cnt + 1'b1;
  assign period_w = {1'b0, period};
  assign diff     = (period_w >= EXP_W) ? period_w - EXP_W : EXP_W - period_w;
  assign good     = diff <= TOL_W;
  assign timeout  = (cnt == TMO) && !edge_rise;
  assign state    = cur;
  assign locked   = (cur == LOCKED);
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      {s1, s2, s3, edge_rise, edge_fall, period_valid} <= '0;
      cnt        <= '0;
      period_out <= '0;
    end else begin
      s1           <= clk_div_in;
      s2           <= s1;
      s3           <= s2;
      edge_rise    <= s2 & ~s3;
      edge_fall    <= ~s2 & s3;
      cnt          <= edge_rise ? '0 : (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
      period_valid <= edge_rise;
      if (edge_rise) period_out <= period;
    end
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) begin
      cur        <= IDLE;
      good_cnt   <= '0;
      lost_pulse <= 1'b0;
    end else begin
      cur        <= nxt;
      good_cnt   <= good_nxt;
      lost_pulse <= lost_nxt;
    end
  // edge_rise wins over timeout because timeout already excludes a rise cycle
  always_comb begin
    nxt      = cur;
    good_nxt = good_cnt;
    lost_nxt = 1'b0;
    case (cur)
      IDLE: if (edge_rise) begin
        nxt      = ACQUIRE;
        good_nxt = '0;
      end
      ACQUIRE: if (edge_rise) begin
        good_nxt = good ? good_cnt + 1'b1 : '0;
        nxt      = (good && good_cnt == GW'(LOCK_CNT - 1)) ? LOCKED : ACQUIRE;
      end else if (timeout) begin
        nxt      = IDLE;
        good_nxt = '0;
      end
      LOCKED: if ((edge_rise && !good) || timeout) begin
        nxt      = LOST;
        lost_nxt = 1'b1;
      end
      LOST: if (edge_rise) begin
        nxt      = ACQUIRE;
        good_nxt = '0;
      end
      default: nxt = IDLE;
    endcase
  end
`ifdef CLK_MON_STICKY_ERR_EN
  always_ff @(posedge clk_in or negedge rst_n)
    if (!rst_n) err_sticky <= 1'b0;
    else        err_sticky <= lost_pulse | (err_sticky & ~err_clr);
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign err_sticky     = 1'b0;
`endif
endmodule

// File: tb/tb_clk_div_monitor.sv
// tb_clk_div_monitor: table-driven periods with a scoreboard of expected period/state per rise,
// plus hand-written timeout, sticky-error and async-reset sequences (honours CLK_MON_STICKY_ERR_EN).
module tb_clk_div_monitor;
  logic clk_in = 1'b0, rst_n = 1'b0, clk_div_in = 1'b0, err_clr = 1'b0;
  logic edge_rise, edge_fall, period_valid, locked, lost_pulse, err_sticky;
  logic [7:0] period_out;
  logic [1:0] state;
  int checks = 0, errors = 0, cyc = 0, lost_n = 0, fall_n = 0, vcyc = 0;
  typedef struct {int p; int chk; int per; int st; int lost;} vec_t;
  vec_t sb[$];
  vec_t tbl[18];
  vec_t relock[5];
`ifdef CLK_MON_STICKY_ERR_EN
  localparam int EXP_ERR = 1;
`else
  localparam int EXP_ERR = 0;
`endif
  clk_div_monitor dut (
    .clk_in(clk_in), .rst_n(rst_n), .clk_div_in(clk_div_in), .err_clr(err_clr),
    .edge_rise(edge_rise), .edge_fall(edge_fall), .period_out(period_out),
    .period_valid(period_valid), .locked(locked), .lost_pulse(lost_pulse),
    .state(state), .err_sticky(err_sticky)
  );
  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk_in) begin
    vec_t e;
    if (lost_pulse) lost_n++;
    if (edge_fall) fall_n++;
    if (period_valid) begin
      vcyc = cyc;
      if (sb.size() == 0) check("unexpected_valid", int'(period_valid), 0);
      else begin
        e = sb.pop_front();
        if (e.chk != 0) check("period_out", int'(period_out), e.per);
        check("state_at_valid", int'(state), e.st);
        check("lost_at_valid", int'(lost_pulse), e.lost);
      end
    end
  end
  // one row = one full clk_div_in period starting with its rising edge
  task automatic drive(input int idx, input vec_t v);
    sb.push_back(v);
    for (int c = 0; c < v.p; c++) begin
      @(negedge clk_in);
      clk_div_in = (c < (v.p + 1) / 2);
      if (idx == 13) begin
        if (c == 0) check("err_before_clr", int'(err_sticky), EXP_ERR);
        err_clr = (c == 1);
        if (c == 3) check("err_after_clr", int'(err_sticky), 0);
      end
    end
  endtask
  initial begin
    bit bad;
    int target;
    tbl = '{'{8, 1, 255, 1, 0}, '{8, 1, 8, 1, 0}, '{8, 1, 8, 1, 0}, '{8, 1, 8, 1, 0},
            '{8, 1, 8, 2, 0},   '{7, 1, 8, 2, 0}, '{9, 1, 7, 2, 0}, '{7, 1, 9, 2, 0},
            '{9, 1, 7, 2, 0},   '{10, 1, 9, 2, 0}, '{8, 1, 10, 3, 1}, '{8, 1, 8, 1, 0},
            '{6, 1, 8, 1, 0},   '{8, 1, 6, 1, 0}, '{8, 1, 8, 1, 0}, '{8, 1, 8, 1, 0},
            '{8, 1, 8, 1, 0},   '{8, 1, 8, 2, 0}};
    relock = '{'{8, 0, 0, 1, 0}, '{8, 1, 8, 1, 0}, '{8, 1, 8, 1, 0}, '{8, 1, 8, 1, 0},
               '{8, 1, 8, 2, 0}};
    #1;
    check("rst_state", int'(state), 0);
    check("rst_period_out", int'(period_out), 0);
    check("rst_flags", int'({edge_rise, edge_fall, period_valid, locked, lost_pulse, err_sticky}), 0);
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    bad = 0;
    repeat (300) begin
      @(negedge clk_in);
      if ({edge_rise, edge_fall, period_out, period_valid, locked, lost_pulse, state, err_sticky} != 0) bad = 1;
    end
    check("idle_quiet", int'(bad), 0);
    for (int i = 0; i < 18; i++) drive(i, tbl[i]);
    // clk_div_in now stuck low: loss must come 10 cycles after the last period_valid
    target = vcyc + 10;
    bad = 0;
    for (int k = 0; k < 40 && cyc != target; k++) begin
      @(negedge clk_in);
      if (cyc != target && lost_pulse) bad = 1;
    end
    check("no_early_lost", int'(bad), 0);
    check("lost_at_t11", int'(lost_pulse), 1);
    err_clr = 1'b1;
    @(negedge clk_in);
    err_clr = 1'b0;
    check("err_set_wins", int'(err_sticky), EXP_ERR);
    check("lost_state", int'(state), 3);
    bad = 0;
    repeat (20) begin
      @(negedge clk_in);
      if (state != 2'd3 || lost_pulse) bad = 1;
    end
    check("stay_lost", int'(bad), 0);
    check("lost_count", lost_n, 2);
    check("fall_count", fall_n, 18);
    for (int i = 0; i < 5; i++) drive(100 + i, relock[i]);
    check("relocked", int'(locked), 1);
    @(negedge clk_in);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_state", int'(state), 0);
    check("async_rst_locked", int'(locked), 0);
    check("async_rst_period", int'(period_out), 0);
    check("async_rst_flags", int'({edge_rise, edge_fall, period_valid, lost_pulse, err_sticky}), 0);
    repeat (3) @(negedge clk_in);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_in);
    check("post_rst_idle", int'(state), 0);
    check("no_lost_on_rst", lost_n, 2);
    check("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end
endmodule
